// File: rtl/pwm_capture.sv
// pwm_capture: eight-channel PWM period / high-time measurement.
// Each channel synchronises its input, detects edges, runs a saturating
// cycle counter restarted on every rising edge, and reports the period and
// high time between successive rising edges. A channel that sees no rising
// edge for TIMEOUT cycles falls back to IDLE and drops its present flag.
module pwm_capture #(
  parameter int unsigned NCH     = 8,
  parameter int unsigned CW      = 32,
  parameter logic [31:0] TIMEOUT = 32'd4_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    pin,
  output logic [NCH*CW-1:0] period,
  output logic [NCH*CW-1:0] high,
  output logic [NCH-1:0]    valid,
  output logic [NCH-1:0]    present
);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

  localparam logic [CW-1:0] TO      = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [NCH-1:0] s1_q, s1_d;
  logic [NCH-1:0] s2_q, s2_d;
  logic [NCH-1:0] s3_q, s3_d;
  logic [NCH-1:0] rise, fall;

  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [CW-1:0]  hl_q  [NCH];
  logic [CW-1:0]  hl_d  [NCH];
  logic [CW-1:0]  per_q [NCH];
  logic [CW-1:0]  per_d [NCH];
  logic [CW-1:0]  hi_q  [NCH];
  logic [CW-1:0]  hi_d  [NCH];
  state_e         state_q [NCH];
  state_e         state_d [NCH];
  logic [NCH-1:0] valid_q, valid_d;
  logic [NCH-1:0] present_q, present_d;

  // Synchroniser chain and edge detection, shared across all channels.
  always_comb begin
    s1_d = pin;
    s2_d = s1_q;
    s3_d = s2_q;
    rise = s2_q & ~s3_q;
    fall = ~s2_q & s3_q;
  end

  // Per-channel counter, high-time latch and IDLE/ARMED next-state logic.
  always_comb begin
    valid_d   = '0;
    present_d = present_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      per_d[i]   = per_q[i];
      hi_d[i]    = hi_q[i];
      hl_d[i]    = fall[i] ? cnt_q[i] : hl_q[i];
      if (rise[i]) begin
        cnt_d[i] = CNT_ONE;
      end else if (&cnt_q[i]) begin
        cnt_d[i] = cnt_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
      case (state_q[i])
        IDLE: begin
          if (rise[i]) begin
            state_d[i] = ARMED;
          end
        end
        ARMED: begin
          // A rise takes priority, so a period of exactly TO is still reported.
          if (rise[i]) begin
            per_d[i]     = cnt_q[i];
            hi_d[i]      = hl_q[i];
            valid_d[i]   = 1'b1;
            present_d[i] = 1'b1;
          end else if (cnt_q[i] >= TO) begin
            state_d[i]   = IDLE;
            present_d[i] = 1'b0;
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // State registers with synchronous reset; a reset discards any partial measurement.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      valid_q   <= '0;
      present_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i]   <= '0;
        hl_q[i]    <= '0;
        per_q[i]   <= '0;
        hi_q[i]    <= '0;
        state_q[i] <= IDLE;
      end
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      valid_q   <= valid_d;
      present_q <= present_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i]   <= cnt_d[i];
        hl_q[i]    <= hl_d[i];
        per_q[i]   <= per_d[i];
        hi_q[i]    <= hi_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  // Pack per-channel results onto the flat output buses.
  always_comb begin
    period  = '0;
    high    = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      period[i*CW +: CW] = per_q[i];
      high[i*CW +: CW]   = hi_q[i];
    end
    valid   = valid_q;
    present = present_q;
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives two pwm_capture instances (32-bit / TIMEOUT 1000 and
// 8-bit / TIMEOUT 255) from the same per-channel PWM generators and compares
// every cycle against a timestamp-based reference model.
module tb_pwm_capture;

  localparam int NCH = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NCH-1:0]  pin;
  logic [NCH*32-1:0] period0, high0;
  logic [NCH-1:0]    valid0, present0;
  logic [NCH*8-1:0]  period1, high1;
  logic [NCH-1:0]    valid1, present1;

  pwm_capture #(.NCH(NCH), .CW(32), .TIMEOUT(32'd1000)) dut0 (
    .clk(clk), .rst(rst), .pin(pin),
    .period(period0), .high(high0), .valid(valid0), .present(present0)
  );

  pwm_capture #(.NCH(NCH), .CW(8), .TIMEOUT(32'd255)) dut1 (
    .clk(clk), .rst(rst), .pin(pin),
    .period(period1), .high(high1), .valid(valid1), .present(present1)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- PWM generators ----------------
  int unsigned g_per [NCH];
  int unsigned g_hi  [NCH];
  int unsigned g_cnt [NCH];
  bit          g_en  [NCH];
  bit          g_stuck [NCH];

  task automatic set_gen(input int ch, input int unsigned p, input int unsigned h);
    g_per[ch] = p; g_hi[ch] = h; g_cnt[ch] = 0; g_en[ch] = 1'b1;
  endtask

  task automatic stop_gen(input int ch, input bit lvl);
    g_en[ch] = 1'b0; g_stuck[ch] = lvl;
  endtask

  // ---------------- reference model ----------------
  // Counter value is derived from the time since the last restart:
  // cnt = min(edge - ref, max).
  longint edge_n = 0;
  longint m_ref [2][NCH];
  longint m_hl  [2][NCH];
  longint m_per [2][NCH];
  longint m_hi  [2][NCH];
  bit     m_armed [2][NCH];
  bit     m_valid [2][NCH];
  bit     m_pres  [2][NCH];
  bit     ms1 [NCH];
  bit     ms2 [NCH];
  bit     ms3 [NCH];
  longint mx [2] = '{64'd4294967295, 64'd255};
  longint to [2] = '{64'd1000, 64'd255};

  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < NCH; i++) begin
        longint cnt;
        bit     r, f;
        if (rst) begin
          m_ref[c][i] = edge_n + 1;
          m_hl[c][i] = 0; m_per[c][i] = 0; m_hi[c][i] = 0;
          m_armed[c][i] = 0; m_valid[c][i] = 0; m_pres[c][i] = 0;
        end else begin
          cnt = edge_n - m_ref[c][i];
          if (cnt > mx[c]) cnt = mx[c];
          r = ms2[i] & ~ms3[i];
          f = ~ms2[i] & ms3[i];
          m_valid[c][i] = 0;
          if (f) m_hl[c][i] = cnt;
          if (r) begin
            if (m_armed[c][i]) begin
              m_per[c][i] = cnt; m_hi[c][i] = m_hl[c][i];
              m_valid[c][i] = 1; m_pres[c][i] = 1;
            end
            m_armed[c][i] = 1;
            m_ref[c][i] = edge_n;
          end else if (m_armed[c][i] && cnt >= to[c]) begin
            m_armed[c][i] = 0; m_pres[c][i] = 0;
          end
        end
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        ms1[i] = 0; ms2[i] = 0; ms3[i] = 0;
      end else begin
        ms3[i] = ms2[i]; ms2[i] = ms1[i]; ms1[i] = pin[i];
      end
    end
    edge_n++;
  endtask

  task automatic compare_all();
    logic [255:0] ep0, eh0, ep1, eh1, ev0, ev1, epr0, epr1;
    ep0 = '0; eh0 = '0; ep1 = '0; eh1 = '0;
    ev0 = '0; ev1 = '0; epr0 = '0; epr1 = '0;
    for (int i = 0; i < NCH; i++) begin
      ep0[i*32 +: 32] = m_per[0][i][31:0];
      eh0[i*32 +: 32] = m_hi[0][i][31:0];
      ep1[i*8 +: 8]   = m_per[1][i][7:0];
      eh1[i*8 +: 8]   = m_hi[1][i][7:0];
      ev0[i] = m_valid[0][i]; ev1[i] = m_valid[1][i];
      epr0[i] = m_pres[0][i]; epr1[i] = m_pres[1][i];
    end
    check_eq("period32",  period0,             ep0);
    check_eq("high32",    high0,               eh0);
    check_eq("valid32",   {248'b0, valid0},    ev0);
    check_eq("present32", {248'b0, present0},  epr0);
    check_eq("period8",   {192'b0, period1},   ep1);
    check_eq("high8",     {192'b0, high1},     eh1);
    check_eq("valid8",    {248'b0, valid1},    ev1);
    check_eq("present8",  {248'b0, present1},  epr1);
  endtask

  // One clock: drive inputs on the falling edge, step the model on the
  // rising edge, compare shortly after it.
  task automatic run(input int unsigned cycles, input bit do_rst);
    for (int unsigned k = 0; k < cycles; k++) begin
      @(negedge clk);
      rst = do_rst;
      for (int i = 0; i < NCH; i++) begin
        if (g_en[i]) begin
          pin[i] = (g_cnt[i] < g_hi[i]);
          g_cnt[i] = (g_cnt[i] + 1) % g_per[i];
        end else begin
          pin[i] = g_stuck[i];
        end
      end
      @(posedge clk);
      model_step();
      #1;
      compare_all();
    end
  endtask

  initial begin
    rst = 1'b1;
    pin = '0;
    for (int i = 0; i < NCH; i++) begin
      g_en[i] = 0; g_stuck[i] = 0; g_per[i] = 1; g_hi[i] = 0; g_cnt[i] = 0;
    end
    // pin[2] held high across reset release.
    g_stuck[2] = 1'b1;
    run(4, 1'b1);
    check_eq("rst_valid", {248'b0, valid0}, 256'd0);
    check_eq("rst_period", period0, 256'd0);

    // Basic measurement on ch0; ch2 starts from its high-at-reset level.
    set_gen(0, 100, 30);
    set_gen(2, 60, 20);
    run(650, 1'b0);
    check_eq("ch0_period", {224'b0, period0[31:0]}, 256'd100);
    check_eq("ch0_high",   {224'b0, high0[31:0]},   256'd30);

    // Saturation on the 8-bit instance, then a measurable waveform.
    set_gen(1, 300, 280);
    run(2000, 1'b0);
    check_eq("sat_period8", {248'b0, period1[15:8]}, 256'd0);
    check_eq("sat_present8", {255'b0, present1[1]}, 256'd0);
    set_gen(1, 250, 10);
    run(1000, 1'b0);
    check_eq("ch1_period8", {248'b0, period1[15:8]}, 256'd250);
    check_eq("ch1_high8",   {248'b0, high1[15:8]},   256'd10);

    // Timeout on ch3 and restart.
    set_gen(3, 200, 50);
    run(1000, 1'b0);
    stop_gen(3, 1'b0);
    run(1200, 1'b0);
    check_eq("to_present", {255'b0, present0[3]}, 256'd0);
    check_eq("to_period",  {224'b0, period0[127:96]}, 256'd200);
    check_eq("to_high",    {224'b0, high0[127:96]},   256'd50);
    set_gen(3, 200, 50);
    run(500, 1'b0);

    // All channels at once, with a reset mid-period.
    for (int i = 0; i < NCH; i++) set_gen(i, 40 + 10 * i, 5 + i);
    run(517, 1'b0);
    run(1, 1'b1);
    check_eq("mid_rst_period", period0, 256'd0);
    check_eq("mid_rst_present", {248'b0, present0}, 256'd0);
    run(400, 1'b0);

    // Loop-back style waveform on ch5.
    set_gen(5, 1000, 150);
    run(3500, 1'b0);
    check_eq("lb_period", {224'b0, period0[191:160]}, 256'd1000);
    check_eq("lb_high",   {224'b0, high0[191:160]},   256'd150);

    // Randomised segments.
    for (int s = 0; s < 20; s++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(9, 0) < 7) begin
          int unsigned p, h;
          p = $urandom_range(400, 4);
          h = $urandom_range(p - 2, 2);
          set_gen(i, p, h);
        end else begin
          stop_gen(i, 1'($urandom_range(1, 0)));
        end
      end
      if ($urandom_range(4, 0) == 0) begin
        run($urandom_range(300, 1), 1'b0);
        run($urandom_range(2, 1), 1'b1);
      end
      run($urandom_range(1500, 400), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Eight-channel PWM measurement block for the servo/actuator subsystem. Each channel samples an asynchronous PWM input and reports the period and high time, in `clk` cycles, between successive rising edges. Results use the same period/high-time units that the PWM generator consumes, so a generator output looped back into this block reads back its programmed timing. It also serves as the decoder for external PWM sources such as RC receivers and servo feedback lines.

## Interface
- `NCH`, 8: number of channels.
- `CW`, 32: counter and result width per channel.
- `TIMEOUT`, 32'd4_000_000: cycles without a rising edge before a channel is declared lost; must be ≤ 2^CW−1 and ≥ 4.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pin`  in  NCH  asynchronous PWM inputs; bit i = channel i.
- `period`  out  NCH*CW  measured period; channel i at bits [i*CW +: CW].
- `high`  out  NCH*CW  measured high time; same packing.
- `valid`  out  NCH  one-cycle pulse when channel i's `period`/`high` update.
- `present`  out  NCH  level; channel i currently producing edges within `TIMEOUT`.

## Operation
- **Input sampling, per channel:**
  - Two-flop synchronizer s1→s2, then delay flop s3.
  - `rise` = s2 & ~s3; `fall` = ~s2 & s3.
- **Running counter `cnt` (CW bits):**
  - `rise`: cnt ← 1.
  - Otherwise: cnt ← cnt+1, saturating at 2^CW−1 (never wraps).
- **High-time latch `hl`:** on `fall`, hl ← cnt (saturated value if saturated).
- **State per channel:** IDLE, ARMED.
  - IDLE + `rise` → ARMED. Counter restarts; no output update.
  - ARMED + `rise` → stays ARMED. Registers update: period ← cnt, high ← hl, `valid` pulses 1 cycle, present ← 1.
  - ARMED + cnt ≥ `TIMEOUT` + no `rise` → IDLE, present ← 0, no `valid`. `period`/`high` hold their last values.
  - `rise` and timeout in the same cycle: `rise` wins, so a measurement of exactly `TIMEOUT` is reported.
- **Constant inputs:** an input stuck high or stuck low produces no rises, so the channel times out to IDLE.
- **Reset (`rst`=1), any time including mid-measurement:**
  - s1/s2/s3, cnt, hl, `period`, `high`, `valid`, `present` all ← 0; state ← IDLE.
  - A partial measurement is discarded.
  - If `pin` is high when reset releases, s2 rises against s3=0. This counts as a rise and only arms the channel.
- **Channel independence:** channels share nothing except `clk`/`rst`; simultaneous events on several channels are all handled in the same cycle.

## Timing
- **Latency:** `pin` transition before edge k → s1 at k, s2 at k+1, `rise`/`fall` true during cycle k+1..k+2. Capture, `valid` and `present` are visible after edge k+2. Total: 3 edges from pin change to output.
- **Period measurement:** rises detected at edges e and e+P report period = P.
- **High-time measurement:** rise detected at e and fall detected at e+H report high = H.
- **Timing units:** a generated waveform with period P cycles and high H cycles reads back exactly P and H, since sampling delay is identical on both edges.
- **Minimum input pulse:** 2 `clk` cycles high and 2 low for guaranteed detection; shorter pulses may be missed, with no other side effect.
- **`valid`:** exactly 1 cycle wide; at most one pulse per input period.
- **Result stability:** `period`/`high` are stable from the `valid` cycle until the next `valid` or `rst`.

## Test plan
- **Basic measurement:** reset 4 cycles, then ch0 = PWM with period 100, high 30.
  - First rise: arms only, no `valid`.
  - Every following rise: `valid[0]` pulse with period=100, high=30, present[0]=1.
  - Other channels: valid=0, present=0.
- **Timeout:** `TIMEOUT`=1000. ch3 runs period 200 / high 50, then the input is held low.
  - `present[3]` falls exactly 1000 cycles after the last detected rise.
  - period/high hold 200/50 with no extra `valid`.
  - Restarting the input: first rise arms only; second rise gives `valid`.
- **Saturation:** `CW`=8, `TIMEOUT`=255, ch1 period 300 / high 280.
  - Channel times out and never reports.
  - Then period 250 / high 10: reports period=250, high=10.
- **Simultaneous channels and reset mid-measurement:**
  - All 8 channels run distinct periods 40+10i / high 5+i; each channel reports its own values on its own `valid`.
  - Assert `rst` for 1 cycle mid-period: all outputs read 0 the next cycle.
  - First post-reset rise gives no `valid`.
- **Loop-back:** PWM generator programmed to period 1000 / high 150 drives ch5; reads back period=1000, high=150 on every `valid`.
- **Pin high at reset release:** `pin[2]`=1 throughout reset, released at edge r.
  - ch2 arms; no `valid` until the next genuine rise.
  - Measured period is counted from the arming cycle.
